alu_ctrl_seq: RTL and testbench

- Registered, parametrised successor to the combinational ALU control decoder in the MIPS pipeline.
- Decodes ALUOp/Function into a CTRL_W-bit ALU control word plus SelShift, and registers the result into the EX stage.
- Sequences multi-cycle operations (mul, clo, clz) with a counter and exposes a ready/busy handshake so ID can stall.
- Supports flush for branch mispredicts.

---
 rtl/alu_ctrl_seq.sv | 142 ++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder for the EX stage with multi-cycle sequencing (mul, clo, clz).
// Optional trap on undecodable ops: define ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_ctrl_seq #(
  parameter int CTRL_W  = 6,
  parameter int MUL_LAT = 4,
  parameter int CNT_LAT = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  input  logic [5:0]        ALUOp,
  input  logic [5:0]        Function,
  input  logic              Stall,
  input  logic              Flush,
  output logic              InReady,
  output logic              CtrlValid,
  output logic [CTRL_W-1:0] ALUControlInput,
  output logic              SelShift,
  output logic              Busy,
  output logic              OpDone,
  output logic              Illegal
);

  localparam int MAXL = (MUL_LAT > CNT_LAT) ? MUL_LAT : CNT_LAT;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] BIT_CNT = CW'(CNT_LAT - 1);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]    code;
    logic          sel;
    logic [CW-1:0] cnt;
    logic          dflt;
  } dec_t;

  dec_t          dec;
  logic [CW-1:0] cnt;
  logic          accept;

  always_comb begin
    dec = '0;
    case (ALUOp)
      6'b000000: dec.code = 6'b000010;
      6'b000001: dec.code = 6'b000110;
      6'b000100,
      6'b001000: dec.code = 6'b010011;
      6'b000110: dec.code = 6'b000111;
      6'b000111: dec.code = 6'b001101;
      6'b001011: dec.code = 6'b000001;
      6'b011001: dec.code = 6'b000000;
      6'b001010: dec.code = 6'b010100;
      6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110: dec.code = ALUOp;
      6'b000010: begin
        case (Function)
          6'b100000, 6'b100001: dec.code = 6'b010011;
          6'b100010: dec.code = 6'b000110;
          6'b100100: dec.code = 6'b000000;
          6'b100101: dec.code = 6'b000001;
          6'b101010: dec.code = 6'b000111;
          6'b100111: dec.code = 6'b001110;
          6'b101011: dec.code = 6'b010100;
          6'b100110: dec.code = 6'b001101;
          6'b000000: begin dec.code = 6'b001000; dec.sel = 1'b1; end
          6'b000010: begin dec.code = 6'b001001; dec.sel = 1'b1; end
          6'b000011: begin dec.code = 6'b001011; dec.sel = 1'b1; end
          6'b000100: dec.code = 6'b010000;
          6'b000110: dec.code = 6'b010001;
          6'b000111: dec.code = 6'b010010;
          6'b001010: dec.code = 6'b001010;
          6'b001011: dec.code = 6'b001111;
          6'b001000: dec.code = 6'b100000;
          default:   begin dec.code = 6'b000010; dec.dflt = 1'b1; end
        endcase
      end
      6'b000101: begin
        case (Function)
          6'b000010: begin dec.code = 6'b000011; dec.cnt = MUL_CNT; end
          6'b100001: begin dec.code = 6'b000100; dec.cnt = BIT_CNT; end
          6'b100000: begin dec.code = 6'b000101; dec.cnt = BIT_CNT; end
          default:   dec.dflt = 1'b1;
        endcase
      end
      default: dec.dflt = 1'b1;
    endcase
    // Trapped ops still issue, as a harmless single-cycle zero code
    if (TRAP && dec.dflt) begin
      dec.code = '0;
      dec.sel  = 1'b0;
      dec.cnt  = '0;
    end
  end

  assign Busy    = CtrlValid && (cnt != '0);
  assign OpDone  = CtrlValid && (cnt == '0);
  assign InReady = !Busy && !Stall;
  assign accept  = InValid && !Flush && !Stall && !Busy;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      CtrlValid       <= 1'b0;
      ALUControlInput <= '0;
      SelShift        <= 1'b0;
      cnt             <= '0;
    end else if (Flush) begin
      CtrlValid       <= 1'b0;
      ALUControlInput <= '0;
      SelShift        <= 1'b0;
      cnt             <= '0;
    end else if (!Stall) begin
      if (accept) begin
        CtrlValid       <= 1'b1;
        ALUControlInput <= CTRL_W'(dec.code);
        SelShift        <= dec.sel;
        cnt             <= dec.cnt;
      end else if (Busy) begin
        cnt <= cnt - 1'b1;
      end else begin
        CtrlValid       <= 1'b0;
        ALUControlInput <= '0;
        SelShift        <= 1'b0;
      end
    end
  end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      Illegal <= 1'b0;
    else if (accept && dec.dflt)
      Illegal <= 1'b1;
  end
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized bench for alu_ctrl_seq against a cycle-level op model, plus directed literal checks.
module tb_alu_ctrl_seq;
  localparam int CTRL_W  = 6;
  localparam int MUL_LAT = 4;
  localparam int CNT_LAT = 2;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic Clk = 1'b0, Rst = 1'b1, InValid = 1'b0, Stall = 1'b0, Flush = 1'b0;
  logic [5:0] ALUOp = '0, Function = '0;
  logic InReady, CtrlValid, SelShift, Busy, OpDone, Illegal;
  logic [CTRL_W-1:0] ALUControlInput;

  alu_ctrl_seq #(.CTRL_W(CTRL_W), .MUL_LAT(MUL_LAT), .CNT_LAT(CNT_LAT)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .ALUOp(ALUOp), .Function(Function),
    .Stall(Stall), .Flush(Flush), .InReady(InReady), .CtrlValid(CtrlValid),
    .ALUControlInput(ALUControlInput), .SelShift(SelShift), .Busy(Busy),
    .OpDone(OpDone), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  int tests = 0, fails = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  typedef struct packed {
    logic [5:0] code;
    logic       sel;
    logic [7:0] lat;
    logic       dflt;
  } rdec_t;

  // Reference decode straight from the opcode table
  function automatic rdec_t ref_dec(input logic [5:0] op, input logic [5:0] fn);
    rdec_t d;
    d = '{code: 6'd0, sel: 1'b0, lat: 8'd1, dflt: 1'b0};
    if (op >= 6'd33 && op <= 6'd38) d.code = op;
    else case (op)
      6'd0:  d.code = 6'd2;
      6'd1:  d.code = 6'd6;
      6'd4, 6'd8: d.code = 6'd19;
      6'd6:  d.code = 6'd7;
      6'd7:  d.code = 6'd13;
      6'd11: d.code = 6'd1;
      6'd25: d.code = 6'd0;
      6'd10: d.code = 6'd20;
      6'd2: case (fn)
        6'h20, 6'h21: d.code = 6'd19;
        6'h22: d.code = 6'd6;
        6'h24: d.code = 6'd0;
        6'h25: d.code = 6'd1;
        6'h2a: d.code = 6'd7;
        6'h27: d.code = 6'd14;
        6'h2b: d.code = 6'd20;
        6'h26: d.code = 6'd13;
        6'h00: begin d.code = 6'd8;  d.sel = 1'b1; end
        6'h02: begin d.code = 6'd9;  d.sel = 1'b1; end
        6'h03: begin d.code = 6'd11; d.sel = 1'b1; end
        6'h04: d.code = 6'd16;
        6'h06: d.code = 6'd17;
        6'h07: d.code = 6'd18;
        6'h0a: d.code = 6'd10;
        6'h0b: d.code = 6'd15;
        6'h08: d.code = 6'd32;
        default: begin d.code = 6'd2; d.dflt = 1'b1; end
      endcase
      6'd5: case (fn)
        6'h02: begin d.code = 6'd3; d.lat = 8'(MUL_LAT); end
        6'h21: begin d.code = 6'd4; d.lat = 8'(CNT_LAT); end
        6'h20: begin d.code = 6'd5; d.lat = 8'(CNT_LAT); end
        default: d.dflt = 1'b1;
      endcase
      default: d.dflt = 1'b1;
    endcase
    if (TRAP && d.dflt) begin
      d.code = 6'd0; d.sel = 1'b0; d.lat = 8'd1;
    end
    return d;
  endfunction

  rdec_t rd;
  always_comb rd = ref_dec(ALUOp, Function);

  // Model: the op in EX and how many more cycles it stays after the current one
  logic       m_valid = 1'b0, m_sel = 1'b0, m_ill = 1'b0;
  logic [5:0] m_code = '0;
  int         m_rem = 0;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_valid <= 1'b0; m_code <= '0; m_sel <= 1'b0; m_rem <= 0; m_ill <= 1'b0;
    end else if (Flush) begin
      m_valid <= 1'b0; m_code <= '0; m_sel <= 1'b0; m_rem <= 0;
    end else if (!Stall) begin
      if (InValid && !(m_valid && m_rem > 0)) begin
        m_valid <= 1'b1; m_code <= rd.code; m_sel <= rd.sel; m_rem <= int'(rd.lat) - 1;
        if (TRAP && rd.dflt) m_ill <= 1'b1;
      end else if (m_valid && m_rem > 0) begin
        m_rem <= m_rem - 1;
      end else begin
        m_valid <= 1'b0; m_code <= '0; m_sel <= 1'b0;
      end
    end
  end

  always @(negedge Clk) begin
    logic e_busy;
    e_busy = m_valid && (m_rem != 0);
    chk("cycle", 32'({CtrlValid, ALUControlInput, SelShift, Busy, OpDone, InReady, Illegal}),
        32'({m_valid, m_code, m_sel, e_busy, m_valid && !e_busy, !e_busy && !Stall, m_ill}));
  end

  logic [5:0] op_tab [16] = '{6'd0, 6'd1, 6'd2, 6'd2, 6'd2, 6'd4, 6'd5, 6'd5,
                              6'd6, 6'd7, 6'd8, 6'd11, 6'd25, 6'd10, 6'd33, 6'd38};
  logic [5:0] fn_tab [16] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h2b,
                              6'h26, 6'h00, 6'h02, 6'h03, 6'h04, 6'h07, 6'h0b, 6'h08};

  initial begin
    int cv_cnt, done_cnt;
    Rst = 1'b1;
    step(); step();
    chk("rst_cv", 32'(CtrlValid), 0);
    chk("rst_code", 32'(ALUControlInput), 0);
    chk("rst_busy_done", 32'({Busy, OpDone, SelShift}), 0);
    chk("rst_ready", 32'(InReady), 1);
    Rst = 1'b0;

    // single add
    InValid = 1'b1; ALUOp = 6'b000010; Function = 6'b100000;
    step(); InValid = 1'b0;
    chk("add_cv", 32'(CtrlValid), 1);
    chk("add_code", 32'(ALUControlInput), 32'b010011);
    chk("add_flags", 32'({SelShift, OpDone, Busy}), 32'b010);
    step();
    chk("add_retire", 32'(CtrlValid), 0);

    // back-to-back sll, sra, xor
    InValid = 1'b1; Function = 6'b000000;
    step(); Function = 6'b000011;
    chk("sll", 32'({ALUControlInput, SelShift, InReady}), 32'b001000_1_1);
    step(); Function = 6'b100110;
    chk("sra", 32'({ALUControlInput, SelShift, InReady}), 32'b001011_1_1);
    step(); InValid = 1'b0;
    chk("xor", 32'({ALUControlInput, SelShift, InReady}), 32'b001101_0_1);
    step();

    // mul with InValid held: next op (add class) only lands after OpDone
    InValid = 1'b1; ALUOp = 6'b000101; Function = 6'b000010;
    step(); ALUOp = 6'b000000;
    chk("mul_c1", 32'({CtrlValid, ALUControlInput, Busy, OpDone, InReady}), 32'b1_000011_1_0_0);
    step();
    chk("mul_c2", 32'({CtrlValid, ALUControlInput, Busy, OpDone}), 32'b1_000011_1_0);
    step();
    chk("mul_c3", 32'({CtrlValid, ALUControlInput, Busy, OpDone}), 32'b1_000011_1_0);
    step();
    chk("mul_c4", 32'({CtrlValid, ALUControlInput, Busy, OpDone}), 32'b1_000011_0_1);
    step(); InValid = 1'b0;
    chk("mul_next", 32'({CtrlValid, ALUControlInput}), 32'b1_000010);
    step(); step();

    // mul stalled 2 cycles mid-op
    InValid = 1'b1; ALUOp = 6'b000101; Function = 6'b000010;
    step(); InValid = 1'b0; Stall = 1'b1;
    cv_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) Stall = 1'b0;
      cv_cnt += int'(CtrlValid);
      done_cnt += int'(OpDone);
      step();
    end
    chk("mul_stall_cv", 32'(cv_cnt), 6);
    chk("mul_stall_done", 32'(done_cnt), 1);

    // clz flushed with a competing InValid
    InValid = 1'b1; ALUOp = 6'b000101; Function = 6'b100000;
    step(); ALUOp = 6'b000000; Flush = 1'b1;
    chk("clz_issue", 32'({ALUControlInput, Busy}), 32'b000101_1);
    step(); Flush = 1'b0; InValid = 1'b0;
    chk("flush", 32'({CtrlValid, ALUControlInput, Busy}), 0);
    step();
    chk("flush_noacc", 32'(CtrlValid), 0);

    // undecodable R-type funct
    InValid = 1'b1; ALUOp = 6'b000010; Function = 6'b111111;
    step(); InValid = 1'b0; Flush = 1'b1;
    chk("ill_code", 32'(ALUControlInput), TRAP ? 32'd0 : 32'b000010);
    chk("ill_flag", 32'(Illegal), 32'(TRAP));
    step(); Flush = 1'b0;
    chk("ill_keep", 32'(Illegal), 32'(TRAP));
    Rst = 1'b1;
    step();
    chk("ill_rst", 32'(Illegal), 0);
    Rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Rst     = ($urandom_range(0, 299) == 0);
      InValid = ($urandom_range(0, 99) < 70);
      Stall   = ($urandom_range(0, 99) < 15);
      Flush   = ($urandom_range(0, 99) < 5);
      ALUOp    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 15)];
      Function = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 15)];
      if (ALUOp == 6'd5 && $urandom_range(0, 1) == 1)
        Function = ($urandom_range(0, 1) == 1) ? 6'h02 : 6'h20;
      step();
    end
    Rst = 1'b0; InValid = 1'b0; Stall = 1'b0; Flush = 1'b0;
    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
